fp_convert_pipe: RTL and testbench

//  Pipelined, parametrised two's-complement to compact floating-point converter (S, E, F).

---
 rtl/fp_conv_pkg.sv | 21 ++
 rtl/fp_lzc.sv | 26 ++
 rtl/fp_convert_pipe.sv | 185 ++++++++++++++++++
 tb/tb_fp_convert_pipe.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_conv_pkg.sv
// Shared constants and helpers for the fixed-to-compact-float converter.
package fp_conv_pkg;

  // Pipeline stage indices into the per-stage valid vector
  localparam int STG_S1  = 0;
  localparam int STG_S2  = 1;
  localparam int STG_S3  = 2;
  localparam int NUM_STG = 3;

  // The sample must keep a sign bit plus at least one dropped bit beyond the
  // significand, and the largest shift must be representable in the exponent.
  function automatic bit fp_params_legal(input int dw, input int ew, input int mw);
    return (dw >= mw + 2) && ((dw - mw - 1) <= ((1 << ew) - 1));
  endfunction

  // Width of the packed {s, e, f, sat, inex} result bundle
  function automatic int fp_result_w(input int ew, input int mw);
    return 1 + ew + mw + 2;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero word reports DW.
module fp_lzc
  import fp_conv_pkg::*;
#(
  parameter int DW = 12,
  parameter int CW = $clog2(DW + 1)
) (
  input  logic [DW-1:0] i_data,
  output logic [CW-1:0] o_cnt
);

  logic w_found;

  // Scan from the MSB and latch the position of the first set bit
  always_comb begin
    o_cnt   = CW'(DW);
    w_found = 1'b0;
    for (int i = DW - 1; i >= 0; i--) begin
      if (!w_found && i_data[i]) begin
        o_cnt   = CW'(DW - 1 - i);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_convert_pipe.sv
// Three-stage two's-complement to (S, E, F) converter with valid/ready
// backpressure. value = F * 2**E; all stages advance on one shared enable.
module fp_convert_pipe
  import fp_conv_pkg::*;
#(
  parameter int DW  = 12,
  parameter int EW  = 3,
  parameter int MW  = 4,
  parameter int RND = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_s,
  output logic [EW-1:0] out_e,
  output logic [MW-1:0] out_f,
  output logic          out_sat,
  output logic          out_inex
);

  localparam int LZW = $clog2(DW + 1);
  localparam int RW  = fp_result_w(EW, MW);

  if (!fp_params_legal(DW, EW, MW)) begin : g_bad_params
    $error("fp_convert_pipe: DW/EW/MW combination cannot represent all inputs");
  end

  // Saturating magnitude: the most negative input has no positive twin, so it
  // is clamped to the largest positive value and flagged. Returns {sat, mag}.
  function automatic logic [DW:0] sat_abs(input logic signed [DW-1:0] x);
    logic signed [DW-1:0] neg;
    neg = -x;
    if (x[DW-1] && (x[DW-2:0] == '0))
      return {1'b1, 1'b0, {(DW-1){1'b1}}};
    else if (x[DW-1])
      return {1'b0, $unsigned(neg)};
    else
      return {1'b0, $unsigned(x)};
  endfunction

  // Round half-up (when enabled), renormalise a significand carry-out, and
  // clamp to all-ones when the exponent overflows. Returns the packed bundle.
  function automatic logic [RW-1:0] round_sat(
    input logic          s,
    input logic [EW-1:0] e,
    input logic [MW-1:0] f,
    input logic          rbit,
    input logic          sticky,
    input logic          sat
  );
    logic [MW:0]   fr;
    logic [EW:0]   ex;
    logic [EW-1:0] eo;
    logic [MW-1:0] fo;
    logic          so;
    fr = {1'b0, f} + {{MW{1'b0}}, (RND != 0) & rbit};
    ex = {1'b0, e};
    so = sat;
    if (fr[MW]) begin
      fr = (MW + 1)'(1) << (MW - 1);
      ex = ex + 1'b1;
    end
    if (ex[EW]) begin
      eo = '1;
      fo = '1;
      so = 1'b1;
    end else begin
      eo = ex[EW-1:0];
      fo = fr[MW-1:0];
    end
    return {s, eo, fo, so, rbit | sticky};
  endfunction

  logic [NUM_STG-1:0]   r_vld;
  logic                 w_adv;

  logic [DW:0]          w_abs_p0;
  logic                 r_s_p0;
  logic                 r_sat_p0;
  logic [DW-1:0]        r_mag_p0;

  logic [LZW-1:0]       w_lz_p1;
  logic [EW-1:0]        w_e_p1;
  logic [MW-1:0]        w_f_p1;
  logic [DW-1:0]        w_half_p1;
  logic [DW-1:0]        w_low_p1;
  logic                 w_rbit_p1;
  logic                 w_sticky_p1;
  logic                 r_s_p1;
  logic                 r_sat_p1;
  logic [EW-1:0]        r_e_p1;
  logic [MW-1:0]        r_f_p1;
  logic                 r_rbit_p1;
  logic                 r_sticky_p1;

  logic [RW-1:0]        w_res_p2;
  logic [RW-1:0]        r_res_p2;

  // A full output slot that is not being taken freezes the whole pipe
  assign w_adv     = out_ready | ~r_vld[STG_S3];
  assign in_ready  = w_adv;
  assign out_valid = r_vld[STG_S3];

  // Stage valids shift together on advance; bubbles travel as zeros
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (w_adv) begin
      r_vld[STG_S1] <= in_valid;
      r_vld[STG_S2] <= r_vld[STG_S1];
      r_vld[STG_S3] <= r_vld[STG_S2];
    end
  end

  // ---- S1: sign and saturating magnitude ----
  assign w_abs_p0 = sat_abs($signed(in_d));

  // Capture sign, magnitude and min-value saturation
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_s_p0   <= in_d[DW-1];
      r_sat_p0 <= w_abs_p0[DW];
      r_mag_p0 <= w_abs_p0[DW-1:0];
    end
  end

  // ---- S2: normalise to MW significant bits ----
  fp_lzc #(
    .DW (DW),
    .CW (LZW)
  ) u_lzc (
    .i_data (r_mag_p0),
    .o_cnt  (w_lz_p1)
  );

  // Small magnitudes fit unshifted; otherwise shift right by E and split the
  // dropped bits into the round bit (just below F) and the sticky remainder
  always_comb begin
    w_e_p1      = '0;
    w_f_p1      = r_mag_p0[MW-1:0];
    w_half_p1   = '0;
    w_low_p1    = '0;
    w_rbit_p1   = 1'b0;
    w_sticky_p1 = 1'b0;
    if (int'(w_lz_p1) < (DW - MW)) begin
      w_e_p1      = EW'(DW - MW - int'(w_lz_p1));
      w_f_p1      = MW'(r_mag_p0 >> w_e_p1);
      w_half_p1   = {{(DW-1){1'b0}}, 1'b1} << (w_e_p1 - 1'b1);
      w_low_p1    = r_mag_p0 & ~({DW{1'b1}} << w_e_p1);
      w_rbit_p1   = |(r_mag_p0 & w_half_p1);
      w_sticky_p1 = |(w_low_p1 & ~w_half_p1);
    end
  end

  // Capture the unrounded exponent/significand and the dropped-bit summary
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_s_p1      <= r_s_p0;
      r_sat_p1    <= r_sat_p0;
      r_e_p1      <= w_e_p1;
      r_f_p1      <= w_f_p1;
      r_rbit_p1   <= w_rbit_p1;
      r_sticky_p1 <= w_sticky_p1;
    end
  end

  // ---- S3: round, renormalise, saturate ----
  assign w_res_p2 = round_sat(r_s_p1, r_e_p1, r_f_p1, r_rbit_p1, r_sticky_p1, r_sat_p1);

  // Output register; cleared on reset so the idle outputs read zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_p2 <= '0;
    end else if (w_adv) begin
      r_res_p2 <= w_res_p2;
    end
  end

  assign {out_s, out_e, out_f, out_sat, out_inex} = r_res_p2;

endmodule

// File: tb/tb_fp_convert_pipe.sv
// Directed-vector and scoreboard bench for fp_convert_pipe (12-bit with and
// without rounding, and a 16/4/6 instance sharing the same handshake).
module tb_fp_convert_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [11:0] in_d = '0;
  logic [15:0] in_d16 = '0;

  logic        in_ready, out_valid, out_s, out_sat, out_inex;
  logic [2:0]  out_e;
  logic [3:0]  out_f;
  logic        in_ready0, out_valid0, out_s0, out_sat0, out_inex0;
  logic [2:0]  out_e0;
  logic [3:0]  out_f0;
  logic        in_ready16, out_valid16, out_s16, out_sat16, out_inex16;
  logic [3:0]  out_e16;
  logic [5:0]  out_f16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_convert_pipe #(.DW(12), .EW(3), .MW(4), .RND(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .out_e(out_e),
    .out_f(out_f), .out_sat(out_sat), .out_inex(out_inex));

  fp_convert_pipe #(.DW(12), .EW(3), .MW(4), .RND(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_d(in_d),
    .out_valid(out_valid0), .out_ready(out_ready), .out_s(out_s0), .out_e(out_e0),
    .out_f(out_f0), .out_sat(out_sat0), .out_inex(out_inex0));

  fp_convert_pipe #(.DW(16), .EW(4), .MW(6), .RND(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16), .in_d(in_d16),
    .out_valid(out_valid16), .out_ready(out_ready), .out_s(out_s16), .out_e(out_e16),
    .out_f(out_f16), .out_sat(out_sat16), .out_inex(out_inex16));

  typedef struct {
    logic [11:0] d;
    int s, e, f, sat, inex;   // RND = 1
    int e0, f0, sat0;         // RND = 0
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: smallest shift that leaves at most mw significant bits,
  // remainder-based rounding, then carry renormalisation and clamping.
  function automatic int model(input int dw, input int ew, input int mw, input int rnd,
                               input longint x);
    longint mag, f, rem;
    int     e;
    bit     s, sat, rbit, inex;
    s   = (x < 0);
    sat = 1'b0;
    if (x == -(longint'(1) << (dw - 1))) begin
      mag = (longint'(1) << (dw - 1)) - 1;
      sat = 1'b1;
    end else begin
      mag = s ? -x : x;
    end
    e = 0;
    while ((mag >> e) >= (longint'(1) << mw)) e++;
    f    = mag >> e;
    rem  = mag - (f << e);
    rbit = (e > 0) && (rem >= (longint'(1) << (e - 1)));
    inex = (rem != 0);
    if (rnd != 0 && rbit) f++;
    if (f == (longint'(1) << mw)) begin
      f = longint'(1) << (mw - 1);
      e++;
    end
    if (e > (1 << ew) - 1) begin
      e   = (1 << ew) - 1;
      f   = (longint'(1) << mw) - 1;
      sat = 1'b1;
    end
    return (int'(s) << (ew + mw + 2)) | (e << (mw + 2)) | (int'(f) << 2) |
           (int'(sat) << 1) | int'(inex);
  endfunction

  function automatic int pk12();
    return int'({out_s, out_e, out_f, out_sat, out_inex});
  endfunction

  function automatic int pk0();
    return int'({out_s0, out_e0, out_f0, out_sat0, out_inex0});
  endfunction

  function automatic int pk16();
    return int'({out_s16, out_e16, out_f16, out_sat16, out_inex16});
  endfunction

  // Streams n samples; mode 0 = 8-sample burst with a 5-cycle out_ready drop,
  // mode 1 = all 4096 12-bit codes (plus random 16-bit) under random backpressure.
  // Entered and left just after a rising edge.
  task automatic run_stream(input int n, input int mode, input int budget);
    int          sent, got, cyc, snap;
    int          q12[$], q0[$], q16[$];
    logic [11:0] burst[8];
    logic [15:0] cur16;
    bit          prev_stall;
    burst = '{12'h00D, 12'hBFF, 12'h02E, 12'h07D, 12'h7FF, 12'h800, 12'h0FF, 12'h123};
    sent = 0; got = 0; cyc = 0; snap = 0; prev_stall = 1'b0;
    cur16 = 16'($urandom);
    while (got < n && cyc < budget) begin
      if (mode == 0) out_ready = !(cyc >= 4 && cyc < 9);
      else           out_ready = ($urandom_range(0, 3) != 0);
      in_valid = (sent < n);
      in_d     = (mode == 0) ? burst[sent % 8] : 12'(sent);
      in_d16   = cur16;
      @(negedge clk);
      if (in_valid && in_ready) begin
        q12.push_back(model(12, 3, 4, 1, longint'($signed(in_d))));
        q0.push_back(model(12, 3, 4, 0, longint'($signed(in_d))));
        q16.push_back(model(16, 4, 6, 1, longint'($signed(in_d16))));
        sent++;
        cur16 = 16'($urandom);
      end
      if (out_valid && out_ready) begin
        if (q12.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stream_extra_output: got %0h with nothing outstanding", pk12());
        end else begin
          chk("stream_rnd1", pk12(), q12.pop_front());
          chk("stream_rnd0", pk0(), q0.pop_front());
          chk("stream_w16", pk16(), q16.pop_front());
        end
        got++;
      end
      if (mode == 0) begin
        if (out_valid && !out_ready) begin
          chk("stall_in_ready", in_ready, 0);
          if (prev_stall) chk("stall_hold", pk12(), snap);
          snap       = pk12();
          prev_stall = 1'b1;
        end else begin
          prev_stall = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", got, n);
    chk("stream_leftover", q12.size(), 0);
  endtask

  initial begin
    int lat;
    int nflush;

    vt[0]  = '{12'h00D, 0, 0, 13, 0, 0, 0, 13, 0};
    vt[1]  = '{12'hBFF, 1, 7,  8, 0, 1, 7,  8, 0};
    vt[2]  = '{12'h02E, 0, 2, 12, 0, 1, 2, 11, 0};
    vt[3]  = '{12'h07D, 0, 4,  8, 0, 1, 3, 15, 0};
    vt[4]  = '{12'h7FF, 0, 7, 15, 1, 1, 7, 15, 0};
    vt[5]  = '{12'h800, 1, 7, 15, 1, 1, 7, 15, 1};
    vt[6]  = '{12'h000, 0, 0,  0, 0, 0, 0,  0, 0};
    vt[7]  = '{12'hFFF, 1, 0,  1, 0, 0, 0,  1, 0};
    vt[8]  = '{12'h010, 0, 1,  8, 0, 0, 1,  8, 0};
    vt[9]  = '{12'h0FF, 0, 5,  8, 0, 1, 4, 15, 0};
    vt[10] = '{12'h00F, 0, 0, 15, 0, 0, 0, 15, 0};
    vt[11] = '{12'h01F, 0, 2,  8, 0, 1, 1, 15, 0};
    vt[12] = '{12'h018, 0, 1, 12, 0, 0, 1, 12, 0};
    vt[13] = '{12'h03F, 0, 3,  8, 0, 1, 2, 15, 0};
    vt[14] = '{12'h7BF, 0, 7, 15, 0, 1, 7, 15, 0};
    vt[15] = '{12'h7C0, 0, 7, 15, 1, 1, 7, 15, 0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_outputs", pk12(), 0);
    chk("rst_out_valid16", out_valid16, 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Directed single-sample vectors, with latency check
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_d     = vt[i].d;
      in_d16   = {{4{vt[i].d[11]}}, vt[i].d};
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk($sformatf("v%0d_latency", i), lat, 3);
      chk($sformatf("v%0d_s", i), out_s, vt[i].s);
      chk($sformatf("v%0d_e", i), out_e, vt[i].e);
      chk($sformatf("v%0d_f", i), out_f, vt[i].f);
      chk($sformatf("v%0d_sat", i), out_sat, vt[i].sat);
      chk($sformatf("v%0d_inex", i), out_inex, vt[i].inex);
      chk($sformatf("v%0d_rnd0_e", i), out_e0, vt[i].e0);
      chk($sformatf("v%0d_rnd0_f", i), out_f0, vt[i].f0);
      chk($sformatf("v%0d_rnd0_sat", i), out_sat0, vt[i].sat0);
      chk($sformatf("v%0d_rnd0_inex", i), out_inex0, vt[i].inex);
    end
    @(posedge clk);
    #1;

    // Burst with a mid-stream stall
    run_stream(8, 0, 80);

    // Reset with three samples in flight
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_d     = (k == 0) ? 12'hBFF : ((k == 1) ? 12'h07D : 12'h800);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("flight_full", out_valid, 1);
    chk("flight_in_ready", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("flight_rst_valid", out_valid, 0);
    chk("flight_rst_in_ready", in_ready, 1);
    chk("flight_rst_outputs", pk12(), 0);
    @(negedge clk);
    chk("flight_rst_valid_nc", out_valid, 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    nflush    = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid || out_valid0 || out_valid16) nflush++;
    end
    chk("flight_none_emitted", nflush, 0);
    @(posedge clk);
    #1;

    // Full 12-bit sweep with random 16-bit samples and random backpressure
    run_stream(4096, 1, 30000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
